// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a host byte stream in preamble/SFD, pads short
// frames with zeros up to MIN_LEN and enforces an inter-packet gap.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter int IPG_LEN      = 12
) (
  input  logic        clk,
  input  logic        mr_main_reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_error,
  output logic        s_ready,
  output logic [7:0]  TXD,
  output logic        TX_EN,
  output logic        TX_ER,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, IPG} state_t;

  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IPG_LAST = 8'(IPG_LEN - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);

  state_t      state_reg;
  logic [3:0]  pre_cnt_reg;
  logic [7:0]  ipg_cnt_reg;
  logic [10:0] byte_cnt_reg;
  logic        last_seen_reg;
  logic [7:0]  txd_reg;
  logic        tx_en_reg;
  logic        tx_er_reg;
  logic [15:0] frame_count_reg;

  logic        transfer;
  logic [10:0] byte_cnt_inc;

  // byte_cnt_reg counts the data/pad byte currently on TXD (1-based).
  assign s_ready      = (state_reg == SFD) || (state_reg == DATA && !last_seen_reg);
  assign busy         = (state_reg != IDLE);
  assign transfer     = s_valid & s_ready;
  assign byte_cnt_inc = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;

  assign TXD         = txd_reg;
  assign TX_EN       = tx_en_reg;
  assign TX_ER       = tx_er_reg;
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_reg       <= IDLE;
      pre_cnt_reg     <= 4'd0;
      ipg_cnt_reg     <= 8'd0;
      byte_cnt_reg    <= 11'd0;
      last_seen_reg   <= 1'b0;
      txd_reg         <= 8'h00;
      tx_en_reg       <= 1'b0;
      tx_er_reg       <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_valid) begin
            state_reg     <= PREAMBLE;
            txd_reg       <= 8'h55;
            tx_en_reg     <= 1'b1;
            tx_er_reg     <= 1'b0;
            pre_cnt_reg   <= 4'd0;
            byte_cnt_reg  <= 11'd0;
            last_seen_reg <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (pre_cnt_reg == PRE_LAST) begin
            state_reg <= SFD;
            txd_reg   <= 8'hD5;
          end else begin
            pre_cnt_reg <= pre_cnt_reg + 4'd1;
          end
        end
        SFD, DATA: begin
          if (last_seen_reg) begin
            // Final payload byte is on TXD now; choose padding or gap.
            txd_reg   <= 8'h00;
            tx_er_reg <= 1'b0;
            if (byte_cnt_reg < MIN_CNT) begin
              state_reg    <= PAD;
              byte_cnt_reg <= byte_cnt_inc;
            end else begin
              state_reg       <= IPG;
              tx_en_reg       <= 1'b0;
              ipg_cnt_reg     <= 8'd0;
              frame_count_reg <= frame_count_reg + 16'd1;
            end
          end else begin
            state_reg    <= DATA;
            byte_cnt_reg <= byte_cnt_inc;
            if (transfer) begin
              txd_reg       <= s_data;
              tx_er_reg     <= s_error;
              last_seen_reg <= s_last;
            end else begin
              // Host underrun: keep the frame going but flag the hole.
              txd_reg   <= 8'h00;
              tx_er_reg <= 1'b1;
            end
          end
        end
        PAD: begin
          if (byte_cnt_reg >= MIN_CNT) begin
            state_reg       <= IPG;
            txd_reg         <= 8'h00;
            tx_en_reg       <= 1'b0;
            tx_er_reg       <= 1'b0;
            ipg_cnt_reg     <= 8'd0;
            frame_count_reg <= frame_count_reg + 16'd1;
          end else begin
            txd_reg      <= 8'h00;
            tx_er_reg    <= 1'b0;
            byte_cnt_reg <= byte_cnt_inc;
          end
        end
        IPG: begin
          if (ipg_cnt_reg == IPG_LAST) begin
            state_reg <= IDLE;
          end else begin
            ipg_cnt_reg <= ipg_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          txd_reg   <= 8'h00;
          tx_en_reg <= 1'b0;
          tx_er_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized scoreboard bench for gmii_tx_framer: the driver pushes the expected
// GMII byte stream per frame, a negedge monitor pops and compares.
module tb_gmii_tx_framer;
  localparam int PREAMBLE_LEN = 7;
  localparam int MIN_LEN      = 60;
  localparam int IPG_LEN      = 12;

  logic        clk = 1'b0;
  logic        mr_main_reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_error = 1'b0;
  logic        s_ready;
  logic [7:0]  TXD;
  logic        TX_EN;
  logic        TX_ER;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  gmii_tx_framer #(
    .PREAMBLE_LEN(PREAMBLE_LEN),
    .MIN_LEN(MIN_LEN),
    .IPG_LEN(IPG_LEN)
  ) dut (
    .clk(clk),
    .mr_main_reset(mr_main_reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_error(s_error),
    .s_ready(s_ready),
    .TXD(TXD),
    .TX_EN(TX_EN),
    .TX_ER(TX_ER),
    .busy(busy),
    .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];      // {tx_er, txd} for every TX_EN=1 cycle
  int         exp_len_q[$];  // TX_EN=1 span per frame
  int         exp_gap_q[$];  // exact preceding gap, 0 = only minimum applies
  logic [7:0] pl_q[$];
  bit         er_q[$];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  int         run_len = 0;
  int         gap_len = 0;
  int         exp_frames = 0;
  bit         prev_seen = 1'b0;
  bit         in_frame = 1'b0;
  logic [8:0] mon_e;
  int         mon_v;

  always @(negedge clk) begin
    if (!mon_en || !mr_main_reset) begin
      run_len = 0; gap_len = 0; exp_frames = 0; prev_seen = 1'b0; in_frame = 1'b0;
      exp_q.delete(); exp_len_q.delete(); exp_gap_q.delete();
    end else if (TX_EN) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        run_len = 0;
        checks++;
        if (exp_gap_q.size() == 0) begin
          errors++;
          $display("FAIL frame_start: unexpected frame at %0t", $time);
        end else begin
          mon_v = exp_gap_q.pop_front();
          if (prev_seen) begin
            if (gap_len < IPG_LEN + 1) begin
              errors++;
              $display("FAIL ipg_min: got %0d idle cycles expected >= %0d", gap_len, IPG_LEN + 1);
            end
            if (mon_v != 0) check("ipg_exact", gap_len, mon_v);
          end
        end
      end
      run_len++;
      check("busy_tx", busy, 1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL txd_extra: got 0x%0h with nothing expected at %0t", TXD, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("txd", TXD, mon_e[7:0]);
        check("tx_er", TX_ER, mon_e[8]);
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        prev_seen = 1'b1;
        gap_len = 0;
        exp_frames++;
        checks++;
        if (exp_len_q.size() == 0) begin
          errors++;
          $display("FAIL frame_len: got %0d with no frame expected", run_len);
        end else begin
          mon_v = exp_len_q.pop_front();
          check("frame_len", run_len, mon_v);
        end
        check("frame_count", frame_count, exp_frames & 16'hFFFF);
      end
      gap_len++;
      check("idle_out", {TX_ER, TXD}, 0);
      check("idle_ready", s_ready, 0);
      if (prev_seen) check("busy_gap", busy, (gap_len <= IPG_LEN) ? 1 : 0);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input logic e);
    int  n;
    bit  took;
    n = 0;
    s_data = d; s_last = l; s_error = e; s_valid = 1'b1;
    forever begin
      took = s_ready;  // stable from negedge until the transfer edge
      @(negedge clk);
      if (took) break;
      n++;
      if (n > 4000) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte 0x%0h never accepted", d);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
    s_data = 8'($urandom);
  endtask

  // Reference model: preamble, SFD, payload (with underrun holes), zero pad.
  task automatic send_frame(input int gap_at, input int gap_n, input bit b2b);
    int cnt;
    int len;
    len = pl_q.size();
    for (int i = 0; i < PREAMBLE_LEN; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({er_q[i], pl_q[i]});
      cnt++;
      if (i == gap_at && i < len - 1) begin
        for (int k = 0; k < gap_n; k++) begin
          exp_q.push_back({1'b1, 8'h00});
          cnt++;
        end
      end
    end
    while (cnt < MIN_LEN) begin
      exp_q.push_back({1'b0, 8'h00});
      cnt++;
    end
    exp_len_q.push_back(PREAMBLE_LEN + 1 + cnt);
    exp_gap_q.push_back(b2b ? IPG_LEN + 1 : 0);
    for (int i = 0; i < len; i++) begin
      send_byte(pl_q[i], (i == len - 1), er_q[i]);
      if (i == gap_at && i < len - 1) repeat (gap_n) @(negedge clk);
    end
  endtask

  task automatic fill_random(input int len, input int err_ratio);
    pl_q.delete(); er_q.delete();
    for (int i = 0; i < len; i++) begin
      pl_q.push_back(8'($urandom));
      er_q.push_back(err_ratio > 0 && $urandom_range(0, err_ratio - 1) == 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_len_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames still expected", exp_len_q.size());
    end
    repeat (IPG_LEN + 2) @(negedge clk);
  endtask

  initial begin
    int len, gap_at, gap_n;
    bit b2b;
    #2 mr_main_reset = 1'b0;
    #1;
    check("rst_txd", TXD, 8'h00);
    check("rst_tx_en", TX_EN, 0);
    check("rst_tx_er", TX_ER, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    repeat (2) @(negedge clk);
    mr_main_reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Short frame 01..04
    pl_q.delete(); er_q.delete();
    for (int i = 1; i <= 4; i++) begin
      pl_q.push_back(8'(i));
      er_q.push_back(1'b0);
    end
    send_frame(-1, 0, 1'b0);

    // Two 64-byte frames back to back
    fill_random(64, 0);
    send_frame(-1, 0, 1'b1);
    fill_random(64, 0);
    send_frame(-1, 0, 1'b1);

    // Underrun: two idle cycles after byte 10
    fill_random(64, 0);
    send_frame(9, 2, 1'b1);

    // Error flag on byte 5 only
    fill_random(64, 0);
    pl_q[4] = 8'hAB;
    er_q[4] = 1'b1;
    send_frame(-1, 0, 1'b1);

    // Length boundaries around MIN_LEN
    fill_random(1, 0);           send_frame(-1, 0, 1'b1);
    fill_random(MIN_LEN - 1, 0); send_frame(-1, 0, 1'b1);
    fill_random(MIN_LEN, 0);     send_frame(-1, 0, 1'b1);
    fill_random(MIN_LEN + 1, 0); send_frame(-1, 0, 1'b1);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 100);
      fill_random(len, 16);
      if ($urandom_range(0, 3) == 0) begin
        gap_at = $urandom_range(0, len - 1);
        gap_n  = $urandom_range(1, 3);
      end else begin
        gap_at = -1;
        gap_n  = 0;
      end
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) repeat ($urandom_range(0, 40)) @(negedge clk);
      send_frame(gap_at, gap_n, b2b);
    end
    drain();

    // Reset in the middle of DATA, then resend
    mon_en = 1'b0;
    @(negedge clk);
    fill_random(64, 0);
    for (int i = 0; i < 20; i++) send_byte(pl_q[i], 1'b0, 1'b0);
    check("pre_rst_tx_en", TX_EN, 1);
    #2 mr_main_reset = 1'b0;
    #1;
    check("mid_rst_txd", TXD, 8'h00);
    check("mid_rst_tx_en", TX_EN, 0);
    check("mid_rst_tx_er", TX_ER, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_count", frame_count, 0);
    @(negedge clk);
    @(negedge clk);
    mr_main_reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    send_frame(-1, 0, 1'b0);
    drain();
    check("final_frame_count", frame_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
